// File: rtl/player_laser_pkg.sv
// Shared definitions for the player laser controller.
//
// Holds the one-hot state encoding for the laser FSM and the play-field
// border constants. The player ship block uses the same border values.
package player_laser_pkg;

    // One-hot laser FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        FLYING = 3'b010,
        DONE   = 3'b100
    } laser_state_t;

    // Play-field borders, in pixels
    localparam logic [9:0] LEFT_BORDER  = 10'd9;
    localparam logic [9:0] RIGHT_BORDER = 10'd630;
    localparam logic [9:0] TOP_BORDER   = 10'd8;

endpackage

// File: rtl/player_laser.sv
// Single-shot player laser controller.
//
// Takes the player's fire request and gun column, launches one laser and
// moves it up by speed_p pixels on every frame tick. A hit from the enemy
// grid, or reaching the top border, ends the shot. The block then spends
// one cycle in DONE and returns to IDLE.
//
// Optional feature (macro PLAYER_LASER_COOLDOWN_EN): after every shot an
// 8-bit counter loads cooldown_p. The counter counts frame ticks while the
// game is not frozen. No new shot is accepted until it reaches zero.
//
// Ports:
//   clk_i           clock
//   reset_ni        asynchronous active-low reset
//   fire_i          fire request from the player (level, edge-detected here)
//   gun_pos_i       gun x position, latched at launch
//   frame_tick_i    one-cycle pulse per video frame
//   freeze_i        game paused; the laser holds its position
//   enemy_hit_i     collision from the enemy grid (level)
//   laser_active_o  laser visible and in flight
//   laser_x_o       laser column
//   laser_y_top_o   top row of the laser
//   laser_y_bot_o   bottom row (y_top + length_p - 1)
//   shot_fired_o    one-cycle pulse on launch
//   hit_enemy_o     one-cycle pulse on hit
//   missed_o        one-cycle pulse when the laser leaves at the top
//   ready_o         a new shot can be launched
//   laser_red_o / laser_green_o / laser_blue_o  constant colour fields
//   state_o         present FSM state, for debug
module player_laser
    import player_laser_pkg::*;
#(
    parameter logic [11:0] color_p      = 12'hF00,
    parameter logic [9:0]  start_y_p    = 10'd440,
    parameter logic [9:0]  length_p     = 10'd16,
    parameter logic [9:0]  speed_p      = 10'd8,
    parameter logic [9:0]  top_border_p = TOP_BORDER,
    parameter logic [7:0]  cooldown_p   = 8'd15
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       fire_i,
    input  logic [9:0] gun_pos_i,
    input  logic       frame_tick_i,
    input  logic       freeze_i,
    input  logic       enemy_hit_i,
    output logic       laser_active_o,
    output logic [9:0] laser_x_o,
    output logic [9:0] laser_y_top_o,
    output logic [9:0] laser_y_bot_o,
    output logic       shot_fired_o,
    output logic       hit_enemy_o,
    output logic       missed_o,
    output logic       ready_o,
    output logic [3:0] laser_red_o,
    output logic [3:0] laser_green_o,
    output logic [3:0] laser_blue_o,
    output logic [2:0] state_o
);

    laser_state_t state_q, state_d;
    logic [9:0]   x_q, x_d;
    logic [9:0]   y_q, y_d;
    logic         fire_q;
    logic         fire_rise;
    logic         cool_ok;
    logic         shot, hit, miss;

    assign fire_rise = fire_i & ~fire_q;

`ifdef PLAYER_LASER_COOLDOWN_EN
    logic [7:0] cool_q;

    // Loads on entry to DONE, then counts unfrozen frame ticks down to zero
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cool_q <= 8'd0;
        end else if (state_d == DONE && state_q != DONE) begin
            cool_q <= cooldown_p;
        end else if (frame_tick_i && !freeze_i && cool_q != 8'd0) begin
            cool_q <= cool_q - 8'd1;
        end
    end

    assign cool_ok = (cool_q == 8'd0);
`else
    logic unused_cooldown;
    assign unused_cooldown = ^cooldown_p;
    assign cool_ok         = 1'b1;
`endif

    // fire_q resets high so that a fire held through reset does not shoot
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            x_q     <= 10'd0;
            y_q     <= start_y_p;
            fire_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fire_q  <= fire_i;
        end
    end

    // Next state, position update and the launch, hit and miss pulses.
    // The border compare comes before the subtract, so y never wraps.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        shot    = 1'b0;
        hit     = 1'b0;
        miss    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire_rise && !freeze_i && cool_ok) begin
                    state_d = FLYING;
                    x_d     = gun_pos_i;
                    y_d     = start_y_p;
                    shot    = 1'b1;
                end
            end
            FLYING: begin
                if (!freeze_i) begin
                    if (enemy_hit_i) begin
                        hit     = 1'b1;
                        state_d = DONE;
                    end else if (frame_tick_i && (y_q < top_border_p + speed_p)) begin
                        miss    = 1'b1;
                        state_d = DONE;
                    end else if (frame_tick_i) begin
                        y_d = y_q - speed_p;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                y_d     = start_y_p;
            end
            default: begin
                state_d = IDLE;
                y_d     = start_y_p;
            end
        endcase
    end

    assign laser_active_o = (state_q == FLYING);
    assign laser_x_o      = x_q;
    assign laser_y_top_o  = y_q;
    assign laser_y_bot_o  = y_q + length_p - 10'd1;
    assign shot_fired_o   = shot;
    assign hit_enemy_o    = hit;
    assign missed_o       = miss;
    assign ready_o        = (state_q == IDLE) && cool_ok;
    assign laser_red_o    = color_p[11:8];
    assign laser_green_o  = color_p[7:4];
    assign laser_blue_o   = color_p[3:0];
    assign state_o        = state_q;

endmodule

// File: doc/player_laser.md
Name: player_laser

Overview:
- Single-shot player laser controller, directly downstream of the player ship block.
- Consumes the player's fire request and gun column, launches one laser, and advances it upward once per frame tick.
- Reports an enemy hit, or a miss at the top border, to the score and enemy logic.
- Provides position and colour to the display mux.

Parameters:
- color_p, 12'hF00, laser colour {R,G,B}, 4 bits each.
- start_y_p, 10'd440, y_top value at launch, just above the ship.
- length_p, 10'd16, laser height in pixels.
- speed_p, 10'd8, pixels moved up per frame tick.
- top_border_p, 10'd8, top limit of the play field.
- cooldown_p, 8'd15, frame ticks before the next shot is allowed. Used only with the optional feature.

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  reset, asynchronous, active-low
- fire_i  in  1  fire request (player shot output), level
- gun_pos_i  in  10  gun x position from the player
- frame_tick_i  in  1  one-cycle pulse per video frame
- freeze_i  in  1  game paused (player hit or dead)
- enemy_hit_i  in  1  collision detect from the enemy grid, level
- laser_active_o  out  1  laser visible and in flight
- laser_x_o  out  10  laser column
- laser_y_top_o  out  10  top row of the laser
- laser_y_bot_o  out  10  bottom row = y_top + length_p - 1
- shot_fired_o  out  1  one-cycle pulse on launch
- hit_enemy_o  out  1  one-cycle pulse on hit
- missed_o  out  1  one-cycle pulse on top-border exit
- ready_o  out  1  a new shot can be launched
- laser_red_o, laser_green_o, laser_blue_o  out  4 each  color_p fields
- state_o  out  3  present state, for debug

Behaviour:
- Reset (async, reset_ni=0):
  - state IDLE; x=0; y_top=start_y_p; fire edge register=1, so a fire held through reset does not shoot.
  - All pulse outputs 0; laser_active_o=0.
- States are one-hot: IDLE=3'b001, FLYING=3'b010, DONE=3'b100. Any other encoding returns to IDLE next cycle.
- Fire edge: fire_rise = fire_i & ~fire_q. fire_q is updated every cycle in every state.
- IDLE:
  - ready_o=1.
  - fire_rise & ~freeze_i -> FLYING next cycle; latch x=gun_pos_i, y_top=start_y_p.
  - shot_fired_o pulses in the same cycle as the transition, so latency is 1 cycle to laser_active_o=1.
- FLYING:
  - laser_active_o=1; ready_o=0.
  - freeze_i=1: hold everything, ignore hit, tick and fire.
  - Else, priority order:
    1. enemy_hit_i (sampled every cycle, no tick needed) -> hit_enemy_o pulse, go to DONE.
    2. frame_tick_i & (y_top < top_border_p + speed_p) -> missed_o pulse, go to DONE.
    3. frame_tick_i -> y_top -= speed_p.
  - Hit in the same cycle as a top-border tick: hit wins, no miss pulse.
  - The compare happens before the subtract, so y_top never underflows. All arithmetic is 10-bit unsigned.
  - fire_rise while FLYING is ignored; there is no queuing.
- DONE:
  - Lasts one cycle; laser_active_o=0; y_top reloads start_y_p; go to IDLE.
  - fire_rise during DONE is dropped.
- laser_y_bot_o is combinational from y_top.
- Colour outputs are constant.

Optional Feature:
- PLAYER_LASER_COOLDOWN_EN defined:
  - On entry to DONE, an 8-bit cooldown counter loads cooldown_p.
  - It decrements on frame_tick_i & ~freeze_i.
  - IDLE accepts fire_rise only when the counter is 0; ready_o = IDLE & (count==0).
  - Reset clears the counter to 0.
- Not defined: no counter; ready_o = (state==IDLE); cooldown_p is unused.

Decomposition:
- Package player_laser_pkg holds:
  - the state enum typedef (one-hot, 3 bits);
  - the play-field border localparams shared with the player block (left 9, right 630, top 8).
- No sub-module. Position and cooldown registers live in-block, because the shared counter uses a synchronous active-high reset, which is incompatible here.

Test Plan:
- Launch: reset, gun_pos_i=265, fire_i rises -> next cycle laser_active_o=1, x=265, y_top=440, y_bot=455; shot_fired_o high exactly 1 cycle.
- Travel and hit: after launch, 5 ticks -> y_top=400; assert enemy_hit_i -> hit_enemy_o 1 cycle, DONE one cycle, IDLE, y_top=440.
- Miss: launch, no hit, 54 ticks -> y_top=8; 55th tick -> missed_o pulse, laser_active_o=0. Same cycle hit+tick at y_top=8 -> hit_enemy_o only.
- Held and repeated fire: fire_i held high for 100 cycles -> exactly one shot. Fire pulsed during FLYING -> ignored, x unchanged.
- Freeze: in flight, freeze_i=1 with ticks and enemy_hit_i -> y_top and state held, no pulses. Release -> flight resumes.
- Reset mid-flight: reset_ni low asynchronously at y_top=200 -> outputs at reset values immediately. With the macro defined: a shot right after a miss is refused until 15 ticks, ready_o=0 meanwhile.
